sound_latch: RTL

- Neo-Geo 68k↔Z80 sound communication block (NEO-C1 sound-code section).
- Sits directly upstream of the Z80 port decoder.
- Latches 68k sound commands and drives the nSDW pulse that the decoder turns into a Z80 NMI.
- Returns Z80 replies to the 68k using the decoder's nSDZ80R/nSDZ80W/nSDZ80CLR strobes.
- All strobes are synchronous to CLK.

---
 rtl/neo_sound_pkg.sv | 11 +
 rtl/strobe_edge.sv | 18 +
 rtl/sound_latch.sv | 104 ++++++++++
 3 files changed

// File: rtl/neo_sound_pkg.sv
// Shared types and defaults for the Neo-Geo 68k<->Z80 sound latch.
package neo_sound_pkg;

    typedef logic [7:0] snd_byte_t;

    localparam int unsigned SNDCNT_W     = 4;
    localparam int unsigned NSDW_LEN_DEF = 4;
    localparam snd_byte_t   CMD_RST_DEF   = 8'h00;
    localparam snd_byte_t   REPLY_RST_DEF = 8'h00;

endpackage

// File: rtl/strobe_edge.sv
// Registers one active-low strobe and flags its rising edge (strobe released).
module strobe_edge (
    input  logic CLK,
    input  logic nRESET,
    input  logic strobe,
    output logic rise_c
);

    logic strobeDly;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) strobeDly <= 1'b1;
        else         strobeDly <= strobe;
    end

    assign rise_c = strobe & ~strobeDly;

endmodule

// File: rtl/sound_latch.sv
// NEO-C1 sound-code section: 68k command latch with nSDW pulse and Z80 reply latch.
// Optional build macro SOUNDLATCH_STATUS_EN adds a status read on M68K_DOUT.
module sound_latch
    import neo_sound_pkg::*;
#(
    parameter int unsigned NSDW_LEN  = NSDW_LEN_DEF,
    parameter snd_byte_t   CMD_RST   = CMD_RST_DEF,
    parameter snd_byte_t   REPLY_RST = REPLY_RST_DEF
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] M68K_DIN,
    input  logic       nLATCH_WR,
    input  logic       nLATCH_RD,
    input  logic       SEL_STATUS,
    output logic [7:0] M68K_DOUT,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    input  logic       nSDZ80R,
    input  logic       nSDZ80W,
    input  logic       nSDZ80CLR,
    output logic       nSDW,
    output logic       CMD_PENDING,
    output logic       REPLY_PENDING
);

    localparam logic [SNDCNT_W-1:0] PULSE_LEN = SNDCNT_W'(NSDW_LEN);
    localparam logic [SNDCNT_W-1:0] CNT_ONE   = SNDCNT_W'(1);

    logic wrEv, rdEv, zrEv, zwEv, zclrEv;
    logic statusSel;
    logic startReq;
    logic [SNDCNT_W-1:0] pulseCnt;
    snd_byte_t cmdShadow, replyShadow, cmdLatch, replyLatch;

    strobe_edge uWr   (.CLK(CLK), .nRESET(nRESET), .strobe(nLATCH_WR), .rise_c(wrEv));
    strobe_edge uRd   (.CLK(CLK), .nRESET(nRESET), .strobe(nLATCH_RD), .rise_c(rdEv));
    strobe_edge uZr   (.CLK(CLK), .nRESET(nRESET), .strobe(nSDZ80R),   .rise_c(zrEv));
    strobe_edge uZw   (.CLK(CLK), .nRESET(nRESET), .strobe(nSDZ80W),   .rise_c(zwEv));
    strobe_edge uZclr (.CLK(CLK), .nRESET(nRESET), .strobe(nSDZ80CLR), .rise_c(zclrEv));

`ifdef SOUNDLATCH_STATUS_EN
    assign statusSel = SEL_STATUS;
    assign M68K_DOUT = SEL_STATUS ? {6'b0, REPLY_PENDING, CMD_PENDING} : replyLatch;
`else
    logic unusedSelStatus;
    assign unusedSelStatus = SEL_STATUS;
    assign statusSel       = 1'b0;
    assign M68K_DOUT       = replyLatch;
`endif

    assign SDD_OUT = cmdLatch;

    // Latches and handshake flags; writers win over clears on the same cycle.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            cmdShadow     <= CMD_RST;
            replyShadow   <= REPLY_RST;
            cmdLatch      <= CMD_RST;
            replyLatch    <= REPLY_RST;
            CMD_PENDING   <= 1'b0;
            REPLY_PENDING <= 1'b0;
        end else begin
            if (!nLATCH_WR) cmdShadow   <= M68K_DIN;
            if (!nSDZ80W)   replyShadow <= SDD_IN;

            if (wrEv) begin
                cmdLatch    <= cmdShadow;
                CMD_PENDING <= 1'b1;
            end else if (zclrEv) begin
                cmdLatch    <= 8'h00;
                CMD_PENDING <= 1'b0;
            end else if (zrEv) begin
                CMD_PENDING <= 1'b0;
            end

            if (zwEv) begin
                replyLatch    <= replyShadow;
                REPLY_PENDING <= 1'b1;
            end else if (rdEv && !statusSel) begin
                REPLY_PENDING <= 1'b0;
            end
        end
    end

    // nSDW pulse; a command landing on the last low cycle holds nSDW low until the reload.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            startReq <= 1'b0;
            pulseCnt <= '0;
            nSDW     <= 1'b1;
        end else begin
            startReq <= wrEv;
            if (startReq) begin
                nSDW     <= 1'b0;
                pulseCnt <= PULSE_LEN;
            end else if (pulseCnt != '0) begin
                pulseCnt <= pulseCnt - CNT_ONE;
                if (pulseCnt == CNT_ONE && !wrEv) nSDW <= 1'b1;
            end
        end
    end

endmodule
